dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// Memory-side responder for the processor/cache word-access stall handshake: accepts one
// read or write request at a time and answers after a fixed LATENCY with a one-cycle ready.
// It backs the cached designs and drives the write-monitor bus (wen/addr/data) that the
// pass/fail checker compares against its answer table.
// PARAMETERS
// DEPTH_LOG2  8   number of words = 2**DEPTH_LOG2; index = addr[DEPTH_LOG2-1:0]
// LATENCY     4   cycles from request acceptance to ready; legal range 1..15
// PORTS
// clk        in   1   clock, all state on rising edge
// rst        in   1   asynchronous active-low reset
// mem_read   in   1   read request, held until mem_ready
// mem_write  in   1   write request, held until mem_ready
// mem_addr   in   30  word address, held with request
// mem_wdata  in   32  write data (little-endian byte order, stored unmodified)
// mem_rdata  out  32  read data, valid only in the mem_ready cycle of a read
// mem_ready  out  1   one-cycle completion pulse
// mon_wen    out  1   one-cycle pulse when a write commits
// mon_addr   out  30  address of committed write (full 30 bits, not the index)
// mon_data   out  32  data of committed write
// rd_count   out  16  completed reads, saturating at 16'hFFFF
// wr_count   out  16  completed writes, saturating at 16'hFFFF
// proto_err  out  1   sticky protocol-violation flag
// oor_err    out  1   sticky flag: accepted addr >= 2**DEPTH_LOG2
// BEHAVIOUR
// - Reset (async, rst low): state IDLE; mem_ready, mon_wen, proto_err, oor_err = 0;
//   mem_rdata, mon_addr, mon_data = 0; rd_count, wr_count = 0; latency counter = 0.
//   Memory array is NOT reset; an in-flight transaction is dropped, no write commits.
// - FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: at an edge with mem_read|mem_write high, latch op, addr, wdata; if LATENCY==1
//         go to RESP, else WAIT with counter = LATENCY-1.
//   WAIT: decrement counter each edge; go to RESP when it reaches 1.
//   RESP: mem_ready=1 for exactly this cycle; next edge -> IDLE unconditionally.
// - Latency: request accepted at edge of cycle T -> mem_ready high in cycle T+LATENCY.
// - Read: mem_rdata = mem[latched index] driven in RESP cycle; 0 outside it.
// - Write: array updated at the edge ending RESP; mon_wen=1, mon_addr/mon_data = latched
//   values during RESP; mon_addr/mon_data hold last committed values otherwise.
// - Both mem_read and mem_write high at acceptance: treated as a write; proto_err set.
// - Request dropped, or addr/wdata/op changed, while in WAIT/RESP: proto_err set;
//   transaction still completes with latched values.
// - Request still high in the cycle after RESP (IDLE): accepted as a new transaction.
// - Out-of-range address: access aliases to addr[DEPTH_LOG2-1:0]; oor_err set.
// - Counters increment at the edge ending RESP; saturate, never wrap.
// - Read of an index written in the same transaction stream returns the latest write
//   (writes commit before any later read can reach RESP).
// STRUCTURE
// - Shared package: FSM state encoding (IDLE/WAIT/RESP), 30-bit address and 32-bit data
//   widths, byte-swap function {d[7:0],d[15:8],d[23:16],d[31:24]} used by benches.
// - One natural sub-module: dmem_array (single-port word RAM, sync write, async read).
// - Counter width: $clog2(16) = 4 bits, sized for LATENCY <= 15.
// TESTING
// - LATENCY=4: write addr 0x1 data 0x02000000 at T -> mem_ready and mon_wen high only in
//   T+4, mon_addr=0x1, mon_data=0x02000000, wr_count=1.
// - Read back addr 0x1 after the write -> mem_rdata=0x02000000 in ready cycle, 0 the
//   cycle before and after; rd_count=1.
// - LATENCY=1: back-to-back reads with request held high -> ready every 2nd cycle,
//   each read counted once; 10 reads give rd_count=10.
// - Read and write asserted together on addr 0x5 -> write commits, proto_err=1; change
//   mem_addr mid-WAIT on a later access -> latched address used, proto_err stays 1.
// - Write addr 0x100 (DEPTH_LOG2=8) data 0xAB -> oor_err=1, read of addr 0x0 returns 0xAB.
// - Pull rst low during WAIT of a write to addr 0x3 -> all outputs 0 immediately, no
//   mon_wen pulse, subsequent read of 0x3 returns the previous contents.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM encoding, bus widths,
// latched-request record and a byte-swap helper.
package dmem_responder_pkg;

   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;
   localparam int CNT_W  = $clog2(16);

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   // Raw request bits are kept separately so a mid-flight change of either is detectable
   typedef struct packed {
      logic  wr;
      logic  rd_raw;
      logic  wr_raw;
      addr_t addr;
      data_t wdata;
   } dmem_req_t;

   function automatic data_t byte_swap(input data_t d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, asynchronous read, contents not reset.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  data_t                 wdata,
   output data_t                 rdata
);

   data_t mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency memory responder for the word-access stall handshake, with
// write-monitor bus, saturating access counters and sticky error flags.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              mon_wen,
   output logic [ADDR_W-1:0] mon_addr,
   output logic [DATA_W-1:0] mon_data,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count,
   output logic              proto_err,
   output logic              oor_err
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

   dmem_state_e      state, state_nxt;
   logic [CNT_W-1:0] cnt;
   dmem_req_t        req;
   addr_t            last_addr;
   data_t            last_data;
   data_t            arr_rdata;

   logic req_any, accept, commit, busy, oor_hit, req_diff;

   assign req_any = mem_read | mem_write;
   assign accept  = (state == IDLE) && req_any;
   assign commit  = (state == RESP);
   assign busy    = (state == WAIT) || (state == RESP);
   assign oor_hit = mem_addr[ADDR_W-1:DEPTH_LOG2] != '0;

   // Request must stay asserted and unchanged from acceptance through the ready cycle
   assign req_diff = !req_any
                  || ({mem_read, mem_write} != {req.rd_raw, req.wr_raw})
                  || (mem_addr != req.addr)
                  || (req.wr && (mem_wdata != req.wdata));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_any) state_nxt = (LATENCY == 1) ? RESP : WAIT;
         WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_ready = (state == RESP);
      mon_wen   = (state == RESP) && req.wr;
      mem_rdata = ((state == RESP) && !req.wr) ? arr_rdata : '0;
      mon_addr  = mon_wen ? req.addr  : last_addr;
      mon_data  = mon_wen ? req.wdata : last_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         req       <= '0;
         last_addr <= '0;
         last_data <= '0;
         rd_count  <= '0;
         wr_count  <= '0;
         proto_err <= 1'b0;
         oor_err   <= 1'b0;
      end else begin
         if (accept) begin
            req.wr     <= mem_write;
            req.rd_raw <= mem_read;
            req.wr_raw <= mem_write;
            req.addr   <= mem_addr;
            req.wdata  <= mem_wdata;
            cnt        <= LAT_M1;
            if (mem_read && mem_write) proto_err <= 1'b1;
            if (oor_hit)               oor_err   <= 1'b1;
         end
         if (state == WAIT)    cnt       <= cnt - CNT_W'(1);
         if (busy && req_diff) proto_err <= 1'b1;
         if (commit) begin
            if (req.wr) begin
               last_addr <= req.addr;
               last_data <= req.wdata;
               if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else if (rd_count != 16'hFFFF) begin
               rd_count <= rd_count + 16'd1;
            end
         end
      end
   end

   dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
      .clk   (clk),
      .we    (commit && req.wr),
      .idx   (req.addr[DEPTH_LOG2-1:0]),
      .wdata (req.wdata),
      .rdata (arr_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   logic        clk;
   logic        rst4, r4, w4;
   logic [29:0] a4;
   logic [31:0] d4;
   logic [31:0] rd4, mdata4;
   logic [29:0] maddr4;
   logic        rdy4, wen4, pe4, oe4;
   logic [15:0] rc4, wc4;

   logic        rst1, r1, w1;
   logic [29:0] a1;
   logic [31:0] d1;
   logic [31:0] rd1, mdata1;
   logic [29:0] maddr1;
   logic        rdy1, wen1, pe1, oe1;
   logic [15:0] rc1, wc1;

   int          n_chk, n_pass;
   int          lat, nwen, nrbad, nrdy, nbad;
   logic [31:0] rdv, mdata;
   logic [29:0] maddr;

   dmem_responder #(.DEPTH_LOG2(8), .LATENCY(4)) u_dut4 (
      .clk(clk), .rst(rst4), .mem_read(r4), .mem_write(w4), .mem_addr(a4),
      .mem_wdata(d4), .mem_rdata(rd4), .mem_ready(rdy4), .mon_wen(wen4),
      .mon_addr(maddr4), .mon_data(mdata4), .rd_count(rc4), .wr_count(wc4),
      .proto_err(pe4), .oor_err(oe4)
   );

   dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst1), .mem_read(r1), .mem_write(w1), .mem_addr(a1),
      .mem_wdata(d1), .mem_rdata(rd1), .mem_ready(rdy1), .mon_wen(wen1),
      .mon_addr(maddr1), .mon_data(mdata1), .rd_count(rc1), .wr_count(wc1),
      .proto_err(pe1), .oor_err(oe1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // Issue one request on the LATENCY=4 instance (called #1 after an edge), hold it
   // through the ready cycle, drop it in the following IDLE cycle.
   task automatic txn4(input logic rd, input logic wr, input logic [29:0] addr,
                       input logic [31:0] wd, input logic chg);
      r4 = rd; w4 = wr; a4 = addr; d4 = wd;
      lat = 0; nwen = 0; nrbad = 0; rdv = '0; maddr = '0; mdata = '0;
      if (rd4 != 32'h0) nrbad++;
      do begin
         @(posedge clk); #1;
         lat++;
         if (wen4) nwen++;
         if (chg && lat == 1) a4 = addr ^ 30'h7;
         if (rdy4) begin
            rdv = rd4; maddr = maddr4; mdata = mdata4;
         end else if (rd4 != 32'h0) begin
            nrbad++;
         end
      end while (!rdy4 && lat < 20);
      @(posedge clk); #1;
      r4 = 1'b0; w4 = 1'b0; a4 = '0;
      if (wen4) nwen++;
      if (rd4 != 32'h0) nrbad++;
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      rst4 = 1'b1; rst1 = 1'b1;
      r4 = 0; w4 = 0; a4 = '0; d4 = '0;
      r1 = 0; w1 = 0; a1 = '0; d1 = '0;
      #2 rst4 = 1'b0; rst1 = 1'b0;
      #1;
      chk("rst_ready",  32'({rdy4, wen4}), 32'h0);
      chk("rst_rdata",  rd4, 32'h0);
      chk("rst_monaddr", 32'(maddr4), 32'h0);
      chk("rst_mondata", mdata4, 32'h0);
      chk("rst_counts", {rc4, wc4}, 32'h0);
      chk("rst_errs",   32'({pe4, oe4}), 32'h0);
      @(posedge clk); #1;
      rst4 = 1'b1; rst1 = 1'b1;
      @(posedge clk); #1;

      // write 0x1, data is little-endian 2
      txn4(1'b0, 1'b1, 30'h1, byte_swap(32'h0000_0002), 1'b0);
      chk("wr1_lat",     32'(lat), 32'd4);
      chk("wr1_nwen",    32'(nwen), 32'd1);
      chk("wr1_monaddr", 32'(maddr), 32'h1);
      chk("wr1_mondata", mdata, 32'h0200_0000);
      chk("wr1_count",   32'(wc4), 32'd1);
      chk("wr1_hold",    32'(maddr4), 32'h1);

      txn4(1'b1, 1'b0, 30'h1, 32'h0, 1'b0);
      chk("rd1_lat",   32'(lat), 32'd4);
      chk("rd1_data",  rdv, 32'h0200_0000);
      chk("rd1_zero",  32'(nrbad), 32'd0);
      chk("rd1_nwen",  32'(nwen), 32'd0);
      chk("rd1_count", 32'(rc4), 32'd1);
      chk("rd1_perr",  32'(pe4), 32'd0);

      // read+write together -> write wins, protocol error
      txn4(1'b1, 1'b1, 30'h5, 32'h55, 1'b0);
      chk("both_mondata", mdata, 32'h55);
      chk("both_perr",    32'(pe4), 32'd1);
      chk("both_wcount",  32'(wc4), 32'd2);
      txn4(1'b1, 1'b0, 30'h5, 32'h0, 1'b0);
      chk("both_rd",      rdv, 32'h55);

      // address changed mid-WAIT: latched 0x6 used, 0x1 untouched
      txn4(1'b0, 1'b1, 30'h6, 32'h66, 1'b1);
      chk("chg_monaddr", 32'(maddr), 32'h6);
      chk("chg_mondata", mdata, 32'h66);
      chk("chg_perr",    32'(pe4), 32'd1);
      txn4(1'b1, 1'b0, 30'h6, 32'h0, 1'b0);
      chk("chg_rd6", rdv, 32'h66);
      txn4(1'b1, 1'b0, 30'h1, 32'h0, 1'b0);
      chk("chg_rd1", rdv, 32'h0200_0000);

      // out-of-range aliasing
      chk("oor_before", 32'(oe4), 32'd0);
      txn4(1'b0, 1'b1, 30'h100, 32'hAB, 1'b0);
      chk("oor_monaddr", 32'(maddr), 32'h100);
      chk("oor_flag",    32'(oe4), 32'd1);
      txn4(1'b1, 1'b0, 30'h0, 32'h0, 1'b0);
      chk("oor_alias", rdv, 32'hAB);

      txn4(1'b0, 1'b1, 30'h3, 32'h33, 1'b0);
      chk("cnt_wr", 32'(wc4), 32'd5);
      chk("cnt_rd", 32'(rc4), 32'd5);

      // reset in the middle of a write to 0x3
      r4 = 1'b0; w4 = 1'b1; a4 = 30'h3; d4 = 32'hDEAD;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst4 = 1'b0; w4 = 1'b0; a4 = '0;
      #1;
      chk("mrst_ready", 32'({rdy4, wen4}), 32'h0);
      chk("mrst_mon",   32'(maddr4) | mdata4, 32'h0);
      chk("mrst_counts", {rc4, wc4}, 32'h0);
      chk("mrst_errs",  32'({pe4, oe4}), 32'h0);
      nwen = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (wen4) nwen++;
      end
      rst4 = 1'b1;
      @(posedge clk); #1;
      if (wen4) nwen++;
      chk("mrst_nwen", 32'(nwen), 32'd0);
      txn4(1'b1, 1'b0, 30'h3, 32'h0, 1'b0);
      chk("mrst_rd3",   rdv, 32'h33);
      chk("mrst_rdcnt", 32'(rc4), 32'd1);

      // LATENCY=1, read held high: ready on every second cycle
      r1 = 1'b1; a1 = 30'h2;
      nrdy = 0; nbad = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (k == 20) r1 = 1'b0;
         if (rdy1) nrdy++;
         if (rdy1 != ((k % 2) == 1)) nbad++;
      end
      @(posedge clk); #1;
      if (rdy1) nrdy++;
      chk("l1_pattern", 32'(nbad), 32'd0);
      chk("l1_nready",  32'(nrdy), 32'd10);
      chk("l1_rdcount", 32'(rc1), 32'd10);
      chk("l1_perr",    32'(pe1), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
